// File: rtl/alu_multicycle.sv
// Handshaked execute-stage ALU with NZCV flag register and a one-bit-per-cycle multiplier.
// Latency: 1 edge for single-cycle ops, WIDTH+1 edges for MUL; the result is held until out_ready.
module alu_multicycle #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] lhs,
  input  logic [WIDTH-1:0] rhs,
  input  logic [4:0]       uop,
  input  logic             set_flags,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_alu,
  output logic [3:0]       flags
);

  localparam int SHW = $clog2(WIDTH);
  localparam logic [SHW-1:0] CNT_LAST = SHW'(WIDTH - 1);

  localparam logic [4:0] OP_ADD = 5'd1;
  localparam logic [4:0] OP_SUB = 5'd2;
  localparam logic [4:0] OP_AND = 5'd3;
  localparam logic [4:0] OP_XOR = 5'd4;
  localparam logic [4:0] OP_CMP = 5'd5;
  localparam logic [4:0] OP_LSL = 5'd6;
  localparam logic [4:0] OP_LSR = 5'd7;
  localparam logic [4:0] OP_MOV = 5'd8;
  localparam logic [4:0] OP_ADC = 5'd9;
  localparam logic [4:0] OP_SBC = 5'd10;
  localparam logic [4:0] OP_ASR = 5'd11;
  localparam logic [4:0] OP_ROR = 5'd12;
  localparam logic [4:0] OP_ORR = 5'd13;
  localparam logic [4:0] OP_MUL = 5'd14;

  typedef enum logic [1:0] {
    S_IDLE,
    S_MUL,
    S_DONE
  } state_t;

  state_t state_q, state_d;

  logic             accept;
  logic             is_mul;

  logic [WIDTH-1:0] addb;
  logic             cin;
  logic [WIDTH:0]   sum;
  logic             add_v;

  logic [7:0]       amt;
  logic [SHW-1:0]   rot_r;
  logic [SHW-1:0]   rot_l;
  logic [WIDTH:0]   lsl_x;
  logic [WIDTH:0]   lsr_x;
  logic signed [WIDTH:0] asr_x;
  logic [WIDTH-1:0] ror_res;

  logic [WIDTH-1:0] alu_res;
  logic [3:0]       alu_flags;
  logic             alu_wr;
  logic             c_new;
  logic             v_new;
  logic             op_ok;
  logic             is_shift;

  logic [WIDTH-1:0] mul_acc;
  logic [WIDTH-1:0] mul_mcand;
  logic [WIDTH-1:0] mul_mplier;
  logic [SHW-1:0]   mul_cnt;
  logic             mul_sf;
  logic [WIDTH-1:0] mul_sum;

  assign in_ready  = (state_q == S_IDLE) | ((state_q == S_DONE) & out_ready);
  assign out_valid = (state_q == S_DONE);
  assign accept    = in_valid & in_ready;
  assign is_mul    = (uop == OP_MUL);

  // Subtraction forms are lhs + ~rhs + cin, which gives ARM-style carry (1 = no borrow).
  always_comb begin
    addb = rhs;
    cin  = 1'b0;
    case (uop)
      OP_SUB, OP_CMP: begin
        addb = ~rhs;
        cin  = 1'b1;
      end
      OP_ADC: cin = flags[2];
      OP_SBC: begin
        addb = ~rhs;
        cin  = flags[2];
      end
      default: ;
    endcase
  end

  assign sum   = {1'b0, lhs} + {1'b0, addb} + {{WIDTH{1'b0}}, cin};
  assign add_v = (lhs[WIDTH-1] == addb[WIDTH-1]) & (sum[WIDTH-1] ^ lhs[WIDTH-1]);

  // One extra bit beside each shifter catches the last bit shifted out as carry.
  assign amt     = rhs[7:0];
  assign lsl_x   = {1'b0, lhs} << amt;
  assign lsr_x   = {lhs, 1'b0} >> amt;
  assign asr_x   = $signed({lhs, 1'b0}) >>> amt;
  assign rot_r   = amt[SHW-1:0];
  assign rot_l   = -rot_r;
  assign ror_res = (lhs >> rot_r) | (lhs << rot_l);

  always_comb begin
    alu_res  = '0;
    c_new    = flags[2];
    v_new    = flags[0];
    op_ok    = 1'b1;
    is_shift = 1'b0;
    case (uop)
      OP_ADD, OP_SUB, OP_CMP, OP_ADC, OP_SBC: begin
        alu_res = sum[WIDTH-1:0];
        c_new   = sum[WIDTH];
        v_new   = add_v;
      end
      OP_AND: alu_res = lhs & rhs;
      OP_XOR: alu_res = lhs ^ rhs;
      OP_ORR: alu_res = lhs | rhs;
      OP_MOV: alu_res = rhs;
      OP_LSL: begin
        alu_res  = lsl_x[WIDTH-1:0];
        c_new    = lsl_x[WIDTH];
        is_shift = 1'b1;
      end
      OP_LSR: begin
        alu_res  = lsr_x[WIDTH:1];
        c_new    = lsr_x[0];
        is_shift = 1'b1;
      end
      OP_ASR: begin
        alu_res  = asr_x[WIDTH:1];
        c_new    = asr_x[0];
        is_shift = 1'b1;
      end
      OP_ROR: begin
        alu_res  = ror_res;
        c_new    = ror_res[WIDTH-1];
        is_shift = 1'b1;
      end
      default: op_ok = 1'b0;
    endcase
    if (is_shift && (amt == 8'd0)) c_new = flags[2];
    alu_flags = {(alu_res == '0), c_new, alu_res[WIDTH-1], v_new};
    alu_wr    = op_ok & (set_flags | (uop == OP_CMP));
  end

  assign mul_sum = mul_acc + (mul_mplier[0] ? mul_mcand : '0);

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: if (accept) state_d = is_mul ? S_MUL : S_DONE;
      S_MUL:  if (mul_cnt == CNT_LAST) state_d = S_DONE;
      S_DONE: begin
        if (out_ready) begin
          if (accept) state_d = is_mul ? S_MUL : S_DONE;
          else        state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      out_alu    <= '0;
      flags      <= 4'b0000;
      mul_acc    <= '0;
      mul_mcand  <= '0;
      mul_mplier <= '0;
      mul_cnt    <= '0;
      mul_sf     <= 1'b0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        if (is_mul) begin
          mul_acc    <= '0;
          mul_mcand  <= lhs;
          mul_mplier <= rhs;
          mul_cnt    <= '0;
          mul_sf     <= set_flags;
        end else begin
          out_alu <= alu_res;
          if (alu_wr) flags <= alu_flags;
        end
      end else if (state_q == S_MUL) begin
        mul_acc    <= mul_sum;
        mul_mcand  <= mul_mcand << 1;
        mul_mplier <= mul_mplier >> 1;
        mul_cnt    <= mul_cnt + 1'b1;
        if (mul_cnt == CNT_LAST) begin
          out_alu <= mul_sum;
          // MUL touches only N and Z.
          if (mul_sf) flags <= {(mul_sum == '0), flags[2], mul_sum[WIDTH-1], flags[0]};
        end
      end
    end
  end

endmodule
